// File: rtl/ras_commit_recovery.sv
// Architectural return address stack updated at commit; on a mispredict it streams its
// contents, oldest first, back to the speculative RAS over a valid/ready handshake.
module ras_commit_recovery #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned RAS_SIZE = 4,
   parameter int unsigned RAS_LEN  = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               commit_valid,
   input  logic               commit_is_call,
   input  logic               commit_is_return,
   input  logic [XLEN-1:0]    commit_PC_plus_4,
   input  logic [XLEN-1:0]    commit_target,
   input  logic               commit_mis_pred,
   output logic               restore_valid,
   output logic [XLEN-1:0]    restore_addr,
   output logic               restore_last,
   input  logic               restore_ready,
   output logic               busy,
   output logic               ret_hit,
   output logic               ret_miss,
   output logic [RAS_LEN:0]   arch_count
);

   typedef enum logic {StIdle, StRestore} state_e;

   localparam logic [RAS_LEN:0]   FullCount = (RAS_LEN+1)'(RAS_SIZE);
   localparam logic [RAS_LEN-1:0] TospRst   = (RAS_LEN)'(RAS_SIZE - 1);

   logic [XLEN-1:0]    stack_q [RAS_SIZE];
   logic [XLEN-1:0]    stack_d [RAS_SIZE];
   logic [RAS_LEN-1:0] tosp_q, tosp_d, push_idx, rd_idx;
   logic [RAS_LEN:0]   count_q, count_d, k_q, k_d;
   state_e             state_q, state_d;
   logic               ret_hit_q, ret_hit_d, ret_miss_q, ret_miss_d;

   assign push_idx = tosp_q + (RAS_LEN)'(1);
   // Oldest valid slot sits count-1 below the top; beats walk upward from there.
   assign rd_idx   = tosp_q - count_q[RAS_LEN-1:0] + (RAS_LEN)'(1) + k_q[RAS_LEN-1:0];

   assign busy          = (state_q == StRestore);
   assign restore_valid = busy;
   assign restore_addr  = busy ? stack_q[rd_idx] : '0;
   assign restore_last  = busy && (k_q == count_q - (RAS_LEN+1)'(1));
   assign ret_hit       = ret_hit_q;
   assign ret_miss      = ret_miss_q;
   assign arch_count    = count_q;

   always_comb begin
      stack_d    = stack_q;
      tosp_d     = tosp_q;
      count_d    = count_q;
      state_d    = state_q;
      k_d        = k_q;
      ret_hit_d  = 1'b0;
      ret_miss_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (commit_valid) begin
               if (commit_is_return && (count_q != '0)) begin
                  ret_hit_d  = (commit_target == stack_q[tosp_q]);
                  ret_miss_d = !ret_hit_d;
                  if (commit_is_call) begin
                     // Call+return replaces the top in place.
                     stack_d[tosp_q] = commit_PC_plus_4;
                  end else begin
                     tosp_d  = tosp_q - (RAS_LEN)'(1);
                     count_d = count_q - (RAS_LEN+1)'(1);
                  end
               end else if (commit_is_call) begin
                  tosp_d            = push_idx;
                  stack_d[push_idx] = commit_PC_plus_4;
                  if (count_q != FullCount) count_d = count_q + (RAS_LEN+1)'(1);
               end
               if (commit_mis_pred && (count_d != '0)) begin
                  state_d = StRestore;
                  k_d     = '0;
               end
            end
         end
         StRestore: begin
            if (restore_ready) begin
               if (restore_last) state_d = StIdle;
               else              k_d     = k_q + (RAS_LEN+1)'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < RAS_SIZE; i++) stack_q[i] <= '0;
         tosp_q     <= TospRst;
         count_q    <= '0;
         k_q        <= '0;
         state_q    <= StIdle;
         ret_hit_q  <= 1'b0;
         ret_miss_q <= 1'b0;
      end else begin
         stack_q    <= stack_d;
         tosp_q     <= tosp_d;
         count_q    <= count_d;
         k_q        <= k_d;
         state_q    <= state_d;
         ret_hit_q  <= ret_hit_d;
         ret_miss_q <= ret_miss_d;
      end
   end

endmodule

// File: doc/ras_commit_recovery.md
# ras_commit_recovery

Retirement-side companion to the speculative return address stack. It maintains an architectural RAS updated only by committed calls (jal) and returns (jalr), and checks each committed return target against the architectural top. On a committed branch mispredict it streams the architectural stack back to the speculative RAS through a valid/ready handshake, oldest entry first. It sits between the ROB commit port and the fetch-stage RAS reload port.

## Interface
- XLEN, 32, address width
- RAS_SIZE, 4, stack entries (power of two)
- RAS_LEN, 2, log2(RAS_SIZE)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset (reset reset, synchronous, active-high; clock clock)
- commit_valid  in  1  an instruction retires this cycle
- commit_is_call  in  1  retiring instruction is a call (jal with rd=ra)
- commit_is_return  in  1  retiring instruction is a return (jalr)
- commit_PC_plus_4  in  XLEN  return address pushed by a call
- commit_target  in  XLEN  actual target of a retiring return
- commit_mis_pred  in  1  retiring instruction mispredicted; pipeline flush
- restore_valid  out  1  restore beat available
- restore_addr  out  XLEN  restore beat data
- restore_last  out  1  qualifies final beat
- restore_ready  in  1  speculative RAS accepts beat
- busy  out  1  restore in progress; speculative RAS push/pop and commit stall
- ret_hit  out  1  one-cycle pulse: committed return matched architectural top
- ret_miss  out  1  one-cycle pulse: committed return mismatched architectural top
- arch_count  out  RAS_LEN+1  valid architectural entries, 0..RAS_SIZE

## Operation
- State: stack[RAS_SIZE] of XLEN, tosp (RAS_LEN bits, last filled slot), count (RAS_LEN+1 bits), FSM {IDLE, RESTORE}, beat index k.
- Reset: stack all 0, tosp = RAS_SIZE-1, count = 0, IDLE; all outputs 0.
- Update rules apply only when commit_valid and state == IDLE:
  - call only: tosp <= tosp+1 (mod RAS_SIZE), stack[tosp+1] <= commit_PC_plus_4; count increments, saturates at RAS_SIZE (oldest overwritten when full).
  - return only, count > 0: compare commit_target to stack[tosp]; pulse ret_hit or ret_miss; tosp <= tosp-1 (mod), count-1.
  - return only, count == 0: no pop, neither pulse.
  - call and return together: compare as for a return if count > 0; stack[tosp] <= commit_PC_plus_4; count unchanged. If count == 0: behaves as a call only.
- commit_mis_pred (with commit_valid): the instruction's own update is applied first, then FSM -> RESTORE with k = 0. If the resulting count is 0, FSM stays IDLE, no beats are sent, and busy stays low.
- RESTORE: restore_valid = 1, restore_addr = stack[(tosp - count + 1 + k) mod RAS_SIZE], restore_last = (k == count-1). On a restore_valid && restore_ready beat, k increments. On the accepted last beat, FSM -> IDLE.
- busy = (state == RESTORE).
- commit_valid while busy is ignored entirely, including call, return and mis_pred; upstream guarantees retirement stalls.
- Stack contents are never cleared by a mispredict; only reset clears them.

## Timing
- Stack, count and tosp update at the clock edge of the commit cycle; arch_count reflects the update the next cycle.
- ret_hit and ret_miss are registered and pulse the cycle after the retiring return.
- restore_valid and busy rise the cycle after commit_mis_pred and stay high until the accepted last beat. They are low the cycle after that beat.
- With restore_ready held high, a restore of N entries takes exactly N cycles.
- restore_addr and restore_last must hold stable while restore_valid && !restore_ready.
- Reset during RESTORE: the next cycle is IDLE with all outputs 0; no further beats.

## Test plan
- Commit calls with PC+4 = 0x100, 0x200, 0x300, then a mis_pred with no call/return -> busy next cycle; 3 beats 0x100, 0x200, 0x300 with restore_last on 0x300; busy low after; arch_count = 3.
- Commit 5 calls (0x10..0x50), then mis_pred -> arch_count = 4; beats 0x20, 0x30, 0x40, 0x50 (0x10 overwritten).
- Calls 0xA0, 0xB0, then return with target 0xB0 -> ret_hit pulse; return with target 0x99 -> ret_miss pulse; arch_count = 0; further return -> no pulse, count stays 0.
- Restore of 2 entries with restore_ready low for 3 cycles on beat 0 -> restore_addr held stable; total 5 cycles busy; a commit_valid call during busy leaves arch_count unchanged.
- mis_pred with empty stack -> busy and restore_valid never assert.
- Calls 0x1, 0x2, mis_pred, reset asserted after first beat accepted -> next cycle busy = 0, arch_count = 0, no further beats.
